npu_add_tree_acc: RTL

Streaming accumulator on the result side of the NPU add tree. It takes the 19-bit signed dot-product partial sums produced each cycle by the 8-lane int8 add tree and accumulates a configurable number of them into one wide saturating sum, so a dot product longer than 8 elements is built from successive tree outputs. It sits between the add tree's registered result and the downstream requantize/write-back stage, with valid/ready handshakes on both sides.

---
 rtl/npu_add_tree_acc.sv | 120 ++++++++++++
 1 files changed

// File: rtl/npu_add_tree_acc.sv
// -----------------------------------------------------------------------------
// npu_add_tree_acc
//   Streaming saturating accumulator behind the 8-lane int8 add tree. Each
//   group of cfg_len 19-bit signed partial sums is folded into one ACC_W-bit
//   signed sum, which is held on the output until downstream accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cfg_len    partial sums per group (0 behaves as 1), sampled on first beat
//   in_valid   partial sum present on in_data
//   in_ready   accumulator accepts in_data this cycle
//   in_data    19-bit signed add-tree result
//   out_valid  completed group sum present
//   out_ready  downstream accepts out_data
//   out_data   ACC_W-bit signed saturated group sum (registered)
//   out_sat    a saturation event occurred in this group (with out_valid)
// -----------------------------------------------------------------------------
module npu_add_tree_acc #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [18:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             sat_q;

  logic             in_fire;
  logic             out_fire;
  logic             start;
  logic [LEN_W-1:0] len_new;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;
  logic [ACC_W-1:0] in_sext;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A new group begins on any accepted beat outside ACC: from IDLE, or in HOLD
  // where acceptance already implies the held result is leaving this cycle.
  assign start   = in_fire & (state_q != ACC);
  assign len_new = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign in_sext = {{(ACC_W-19){in_data[18]}}, in_data};

  // One guard bit: overflow shows up as the guard disagreeing with the MSB,
  // and the guard alone gives the direction of the clamp.
  assign sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-18){in_data[18]}}, in_data};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = !sum_ovf    ? sum[ACC_W-1:0] :
                   sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                 {1'b0, {(ACC_W-1){1'b1}}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_fire) state_d = (len_new == LEN_W'(1)) ? HOLD : ACC;
      ACC:  if (in_fire && (LEN_W'(cnt_q + 1'b1) == len_q)) state_d = HOLD;
      HOLD: if (out_fire) begin
              if (in_fire) state_d = (len_new == LEN_W'(1)) ? HOLD : ACC;
              else         state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q == HOLD) ? out_ready : 1'b1;
    out_data  = acc_q;
    out_sat   = sat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else if (start) begin
      acc_q <= in_sext;
      cnt_q <= LEN_W'(1);
      len_q <= len_new;
      sat_q <= 1'b0;
    end else if (in_fire) begin
      acc_q <= sum_sat;
      cnt_q <= LEN_W'(cnt_q + 1'b1);
      if (sum_ovf) sat_q <= 1'b1;
    end
  end

endmodule
